// File: rtl/signed_mul_add_seq.sv
// Sequential signed multiply-add: result = a*b + c over WIDTH cycles.
// Magnitudes are multiplied with shift-add, then the product's sign is restored
// and the sign-extended addend is added in a single fix-up cycle.
module signed_mul_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t               state;
  logic                 sign;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     c_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        count;

  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   prod_signed;
  logic [2*WIDTH-1:0]   c_ext;

  // |-2^(W-1)| wraps to 2^(W-1), which is exactly right when read as unsigned
  assign a_abs       = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_abs       = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign partial     = {{WIDTH{1'b0}}, a_mag} << count;
  assign prod_signed = sign ? (~acc + (2*WIDTH)'(1)) : acc;
  assign c_ext       = {{WIDTH{c_reg[WIDTH-1]}}, c_reg};
  assign in_ready    = (state == IDLE);

  // Control FSM and datapath: capture, shift-add one multiplier bit per cycle, fix sign, hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sign      <= 1'b0;
      a_mag     <= '0;
      b_mag     <= '0;
      c_reg     <= '0;
      acc       <= '0;
      count     <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign  <= a[WIDTH-1] ^ b[WIDTH-1];
            a_mag <= a_abs;
            b_mag <= b_abs;
            c_reg <= c;
            acc   <= '0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (b_mag[0]) begin
            acc <= acc + partial;
          end
          b_mag <= b_mag >> 1;
          count <= count + CW'(1);
          if (count == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          result    <= prod_signed + c_ext;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_mul_add_seq.sv
// Self-checking bench for signed_mul_add_seq (WIDTH=8): directed cases with
// literal expectations, a divider round-trip sample and randomized traffic
// checked every cycle against a transaction-level model.
module tb_signed_mul_add_seq;

  localparam int W   = 8;
  localparam int LAT = W + 1;

  logic                  clk       = 1'b0;
  logic                  rst_n     = 1'b0;
  logic                  in_valid  = 1'b0;
  logic                  in_ready;
  logic signed [W-1:0]   a         = '0;
  logic signed [W-1:0]   b         = '0;
  logic signed [W-1:0]   c         = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [2*W-1:0]        result;

  int errors = 0;
  int checks = 0;

  // Model state: busy from accept until handshake, valid after LAT edges
  bit             m_busy   = 1'b0;
  bit             m_valid  = 1'b0;
  int             m_edges  = 0;
  logic [2*W-1:0] m_exp    = '0;
  logic [2*W-1:0] m_result = '0;

  signed_mul_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [W-1:0] pick();
    case ($urandom % 6)
      0:       return -8'sd128;
      1:       return 8'sd127;
      2:       return 8'sd0;
      3:       return -8'sd1;
      default: return W'($urandom);
    endcase
  endfunction

  // Transaction-level reference: expected value is plain integer a*b+c, taken mod 2^16
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_edges  <= 0;
      m_result <= '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy  <= 1'b1;
        m_edges <= 0;
        m_exp   <= 16'(int'(a) * int'(b) + int'(c));
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else begin
      m_edges <= m_edges + 1;
      if (m_edges + 1 == LAT) begin
        m_valid  <= 1'b1;
        m_result <= m_exp;
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      compare("in_ready", {15'b0, in_ready}, {15'b0, !m_busy});
      compare("out_valid", {15'b0, out_valid}, {15'b0, m_valid});
      if (m_valid) compare("result", result, m_result);
    end
  end

  task automatic applyStimulus(input logic signed [W-1:0] ta, input logic signed [W-1:0] tb,
                               input logic signed [W-1:0] tc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    compare("accept_wait", {15'b0, in_ready}, 16'd1);
    a = ta;
    b = tb;
    c = tc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    c = W'($urandom);
  endtask

  task automatic checkOutput(input string name, input logic [2*W-1:0] exp, input int hold);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    compare({name, "_latency"}, 16'(n), 16'(LAT));
    compare({name, "_result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i[0] == 1'b0);
      a = W'($urandom);
      b = W'($urandom);
      c = W'($urandom);
      @(negedge clk);
      compare({name, "_hold_result"}, result, exp);
      compare({name, "_hold_in_ready"}, {15'b0, in_ready}, 16'd0);
      compare({name, "_hold_out_valid"}, {15'b0, out_valid}, 16'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    compare({name, "_idle_in_ready"}, {15'b0, in_ready}, 16'd1);
    compare({name, "_idle_out_valid"}, {15'b0, out_valid}, 16'd0);
  endtask

  // Main sequence: reset, directed cases, backpressure, mid-run reset, round-trip, random
  initial begin
    logic signed [W-1:0] td;
    logic signed [W-1:0] tv;
    int dd, dv, q, r;

    #12;
    compare("reset_result", result, 16'd0);
    compare("reset_out_valid", {15'b0, out_valid}, 16'd0);
    compare("reset_in_ready", {15'b0, in_ready}, 16'd1);
    #10 rst_n = 1'b1;

    applyStimulus(-8'sd7, 8'sd5, -8'sd3);
    checkOutput("neg7x5m3", 16'hFFDA, 0);
    applyStimulus(-8'sd128, -8'sd128, 8'sd0);
    checkOutput("m128xm128", 16'h4000, 0);
    applyStimulus(-8'sd128, 8'sd127, -8'sd128);
    checkOutput("m128x127", 16'hC000, 0);
    applyStimulus(-8'sd14, 8'sd7, -8'sd2);
    checkOutput("div_m100_7", 16'hFF9C, 0);
    applyStimulus(8'sd13, 8'sd0, -8'sd5);
    checkOutput("b_zero", 16'hFFFB, 0);
    applyStimulus(8'sd0, -8'sd1, 8'sd127);
    checkOutput("a_zero", 16'h007F, 0);

    applyStimulus(8'sd45, -8'sd11, 8'sd100);
    checkOutput("backpressure", 16'hFE75, 6);

    applyStimulus(8'sd25, -8'sd3, 8'sd9);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    compare("midrun_reset_out_valid", {15'b0, out_valid}, 16'd0);
    compare("midrun_reset_result", result, 16'd0);
    compare("midrun_reset_in_ready", {15'b0, in_ready}, 16'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(8'sd3, 8'sd4, 8'sd1);
    checkOutput("after_reset", 16'd13, 0);

    for (int i = 0; i < 200; i++) begin
      td = W'($urandom);
      tv = W'($urandom);
      if (tv == 0) tv = 8'sd1;
      if (td == -8'sd128 && tv == -8'sd1) tv = 8'sd3;
      dd = td;
      dv = tv;
      q  = dd / dv;
      r  = dd % dv;
      applyStimulus(W'(q), W'(dv), W'(r));
      checkOutput("roundtrip", 16'(dd), 0);
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom % 3) != 0;
      a         = pick();
      b         = pick();
      c         = pick();
      out_ready = ($urandom % 4) != 0;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
